// File: rtl/pc_seq_pkg.sv
// Shared op-codes and FSM state encodings for the PC sequencer.
package pc_seq_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_BRA  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_INT  = 3'b110;
  localparam logic [2:0] OP_IRET = 3'b111;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_INT   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO of DEPTH entries with level/full/empty flags.
// Entries are not cleared by reset; only the level is.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     top_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [LVL_W-1:0] top_idx;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign top_idx = level - LVL_W'(1);
  assign top_data = empty ? '0 : mem[top_idx[IDX_W-1:0]];

  // Occupancy counter; the parent never asserts push when full or pop when empty.
  always_ff @(posedge clk) begin
    if (!rst_n)
      level <= '0;
    else if (push && !full)
      level <= level + LVL_W'(1);
    else if (pop && !empty)
      level <= level - LVL_W'(1);
  end

  // Entry storage, written at the current level on push.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[level[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: PC register, RUN/INT_SVC/FAULT FSM and a
// return-address stack shared by CALL/RET and INT/IRET.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               DATA_W    = 32,
  parameter int               ADDR_W    = 13,
  parameter int               RAS_DEPTH = 4,
  parameter logic [DATA_W-1:0] INT_VEC  = 'h0000E000,
  parameter logic [DATA_W-1:0] RESET_VEC = '0
) (
  input  logic                             clk_pc,
  input  logic                             reset_pc,
  input  logic                             pc_en,
  input  logic [2:0]                       pc_op,
  input  logic [DATA_W-1:0]                data_in,
  input  logic                             AD_sel,
  output logic [ADDR_W-1:0]                Address_line,
  output logic [DATA_W-1:0]                pc_value,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_level,
  output logic                             int_active,
  output logic                             fault
);

  localparam int LVL_W = $clog2(RAS_DEPTH + 1);

  logic [DATA_W-1:0] pc, pc_nxt, pc_inc, top_data;
  logic [1:0]        st, st_nxt;
  logic              push, pop, full, empty;

  assign pc_inc = pc + DATA_W'(1);

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (DATA_W),
    .LVL_W (LVL_W)
  ) u_ras (
    .clk       (clk_pc),
    .rst_n     (reset_pc),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (top_data),
    .level     (ras_level),
    .full      (full),
    .empty     (empty)
  );

  // Next-state decode. Stack overflow/underflow diverts to FAULT without
  // touching pc or the stack; FAULT ignores everything until reset.
  always_comb begin
    pc_nxt = pc;
    st_nxt = st;
    push   = 1'b0;
    pop    = 1'b0;
    if (pc_en && st != ST_FAULT) begin
      case (pc_op)
        OP_INC:  pc_nxt = pc_inc;
        OP_JMP:  pc_nxt = data_in;
        OP_BRA:  pc_nxt = pc + data_in;
        OP_CALL: begin
          if (full) st_nxt = ST_FAULT;
          else begin
            push   = 1'b1;
            pc_nxt = data_in;
          end
        end
        OP_RET: begin
          if (empty) st_nxt = ST_FAULT;
          else begin
            pop    = 1'b1;
            pc_nxt = top_data;
          end
        end
        OP_INT: begin
          // No nesting: INT while already in service is a HOLD.
          if (st == ST_RUN) begin
            if (full) st_nxt = ST_FAULT;
            else begin
              push   = 1'b1;
              pc_nxt = INT_VEC;
              st_nxt = ST_INT;
            end
          end
        end
        OP_IRET: begin
          if (st != ST_INT || empty) st_nxt = ST_FAULT;
          else begin
            pop    = 1'b1;
            pc_nxt = top_data;
            st_nxt = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge clk_pc) begin
    if (!reset_pc) begin
      pc <= RESET_VEC;
      st <= ST_RUN;
    end else begin
      pc <= pc_nxt;
      st <= st_nxt;
    end
  end

  assign pc_value     = pc;
  assign Address_line = AD_sel ? pc[ADDR_W-1:0] : '0;
  assign int_active   = (st == ST_INT);
  assign fault        = (st == ST_FAULT);

endmodule
